// File: rtl/aipp_multi_trigger.sv
// aipp_multi_trigger: per-channel detect -> VRM pre-charge pulse -> delayed, handshaked data release.
// Channels are independent copies of one three-process FSM with delay clamping, abort and drop counting.
module aipp_multi_trigger #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 32,
   parameter int TRIG_PULSE = 4,
   parameter int MIN_DELAY  = 2,
   parameter int DROP_W     = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          packet_detect,
   input  logic [NUM_CH*CNT_W-1:0]    delay_ns,
   input  logic [NUM_CH-1:0]          abort,
   input  logic [NUM_CH-1:0]          release_ack,
   output logic [NUM_CH-1:0]          vrm_trigger,
   output logic [NUM_CH-1:0]          data_release,
   output logic [NUM_CH-1:0]          busy,
   output logic [NUM_CH*DROP_W-1:0]   drop_count
);
   localparam int PW = $clog2(TRIG_PULSE + 1);
   typedef enum logic [1:0] {IDLE, LEAD, RELEASE} state_t;
   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         state_t              state_q, state_d;
         logic [CNT_W-1:0]    cnt_q, cnt_d, dly, d_eff;
         logic [PW-1:0]       pls_q, pls_d, p_eff;
         logic [DROP_W-1:0]   drop_q, drop_d;
         logic                vrm_q, vrm_d, rel_q, rel_d, busy_q, busy_d;
         logic                pd, ab, ack, accept, drop;
         assign pd    = packet_detect[g];
         assign ab    = abort[g];
         assign ack   = release_ack[g];
         assign dly   = delay_ns[g*CNT_W +: CNT_W];
         assign d_eff = (dly < CNT_W'(MIN_DELAY)) ? CNT_W'(MIN_DELAY) : dly;
         // pulse length is the shorter of TRIG_PULSE and the effective delay
         assign p_eff = (d_eff < CNT_W'(TRIG_PULSE)) ? PW'(d_eff) : PW'(TRIG_PULSE);
         assign accept = pd && !ab && (state_q == IDLE || (state_q == RELEASE && ack));
         assign drop   = pd && ((state_q == IDLE && ab) || state_q == LEAD ||
                                (state_q == RELEASE && (!ack || ab)));
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q <= IDLE;
               cnt_q   <= '0;
               pls_q   <= '0;
               drop_q  <= '0;
               vrm_q   <= 1'b0;
               rel_q   <= 1'b0;
               busy_q  <= 1'b0;
            end else begin
               state_q <= state_d;
               cnt_q   <= cnt_d;
               pls_q   <= pls_d;
               drop_q  <= drop_d;
               vrm_q   <= vrm_d;
               rel_q   <= rel_d;
               busy_q  <= busy_d;
            end
         end
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pls_d   = pls_q;
            if (accept) begin
               state_d = LEAD;
               cnt_d   = d_eff;
               pls_d   = p_eff;
            end else if (state_q == LEAD) begin
               state_d = ab ? IDLE : ((cnt_q == CNT_W'(1)) ? RELEASE : LEAD);
               cnt_d   = ab ? '0 : cnt_q - CNT_W'(1);
               pls_d   = ab ? '0 : pls_q - PW'(pls_q != '0);
            end else if (state_q == RELEASE && ack) begin
               state_d = IDLE;
            end
            drop_d = (drop && !(&drop_q)) ? drop_q + DROP_W'(1) : drop_q;
         end
         always_comb begin
            vrm_d  = (state_d == LEAD) && (pls_d != '0);
            rel_d  = (state_d == RELEASE);
            busy_d = (state_d != IDLE);
         end
         assign vrm_trigger[g]                  = vrm_q;
         assign data_release[g]                 = rel_q;
         assign busy[g]                         = busy_q;
         assign drop_count[g*DROP_W +: DROP_W]  = drop_q;
      end
   endgenerate
endmodule

// File: tb/tb_aipp_multi_trigger.sv
// tb_aipp_multi_trigger: scenario tasks plus random traffic, checked against a timestamp-based channel model.
module tb_aipp_multi_trigger;
   localparam int NC = 4, CW = 32, TP = 4, MD = 2, DW = 4;
   localparam int DMAX = (1 << DW) - 1;
   logic clk = 1'b0, rst_n = 1'b1;
   logic [NC-1:0] packet_detect = '0, abort = '0, release_ack = '0;
   logic [NC*CW-1:0] delay_ns = '0;
   logic [NC-1:0] vrm_trigger, data_release, busy;
   logic [NC*DW-1:0] drop_count;
   logic [27:0] dut_v;
   int errors = 0, checks = 0, cyc = 0;
   bit act[NC], rel[NC];
   int e0[NC], dd[NC], drp[NC];

   aipp_multi_trigger #(.NUM_CH(NC), .CNT_W(CW), .TRIG_PULSE(TP), .MIN_DELAY(MD), .DROP_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .packet_detect(packet_detect), .delay_ns(delay_ns),
      .abort(abort), .release_ack(release_ack), .vrm_trigger(vrm_trigger),
      .data_release(data_release), .busy(busy), .drop_count(drop_count));

   always #5 clk = ~clk;
   assign dut_v = {vrm_trigger, data_release, busy, drop_count};

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         act[c] = 0; rel[c] = 0; e0[c] = 0; dd[c] = 0; drp[c] = 0;
      end
   endtask

   task automatic bump(input int c);
      if (drp[c] < DMAX) drp[c]++;
   endtask

   // channel model: a packet accepted at edge e0 with delay d pulses for min(TP,d) edges and releases at e0+d
   task automatic step(input logic [NC-1:0] pd, input logic [NC-1:0] ab, input logic [NC-1:0] ack);
      packet_detect = pd; abort = ab; release_ack = ack;
      @(posedge clk);
      cyc++;
      if (rst_n) for (int c = 0; c < NC; c++) begin
         int d;
         d = int'(delay_ns[c*CW +: CW]);
         if (d < MD) d = MD;
         if (act[c] && !rel[c]) begin
            if (pd[c]) bump(c);
            if (ab[c]) act[c] = 0;
            else if (cyc == e0[c] + dd[c]) rel[c] = 1;
         end else if (act[c] && !ack[c]) begin
            if (pd[c]) bump(c);
         end else begin
            act[c] = 0; rel[c] = 0;
            if (pd[c] && ab[c]) bump(c);
            else if (pd[c]) begin act[c] = 1; e0[c] = cyc; dd[c] = d; end
         end
      end
      #1;
      packet_detect = '0; abort = '0; release_ack = '0;
   endtask

   function automatic logic [27:0] exp_v();
      logic [NC-1:0] v, r, b;
      logic [NC*DW-1:0] dc;
      for (int c = 0; c < NC; c++) begin
         b[c] = act[c];
         r[c] = rel[c];
         v[c] = act[c] && !rel[c] && ((cyc - e0[c]) < ((dd[c] < TP) ? dd[c] : TP));
         dc[c*DW +: DW] = DW'(drp[c]);
      end
      return {v, r, b, dc};
   endfunction

   function automatic logic [NC-1:0] rel_bits();
      logic [NC-1:0] r;
      for (int c = 0; c < NC; c++) r[c] = rel[c];
      return r;
   endfunction

   task automatic test_reset();
      model_reset();
      #2 rst_n = 1'b0;
      #1;
      if (dut_v !== 28'h0) begin errors++; $display("FAIL reset_async got=%h exp=%h", dut_v, 28'h0); end
      checks++;
      @(posedge clk); @(posedge clk); #1;
      if (dut_v !== exp_v()) begin errors++; $display("FAIL reset_hold got=%h exp=%h", dut_v, exp_v()); end
      checks++;
      rst_n = 1'b1;
      step('0, '0, '0);
      if (dut_v !== exp_v()) begin errors++; $display("FAIL reset_release got=%h exp=%h", dut_v, exp_v()); end
      checks++;
   endtask

   task automatic test_basic();
      delay_ns[0 +: CW] = 10;
      for (int i = 0; i < 15; i++) begin
         step({3'b0, i == 0}, '0, {3'b0, i == 12});
         if (dut_v !== exp_v()) begin errors++; $display("FAIL basic i=%0d got=%h exp=%h", i, dut_v, exp_v()); end
         checks++;
         if (i == 10 && data_release[0] !== 1'b1) begin errors++; $display("FAIL basic_rise got=%b exp=1", data_release[0]); end
         if (i == 10) checks++;
      end
      if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_idle busy=%b exp=0", busy[0]); end
      checks++;
   endtask

   task automatic test_clamp();
      for (int k = 0; k < 2; k++) begin
         delay_ns[0 +: CW] = k;
         for (int i = 0; i < 5; i++) begin
            step({3'b0, i == 0}, '0, rel_bits());
            if (dut_v !== exp_v()) begin errors++; $display("FAIL clamp d=%0d i=%0d got=%h exp=%h", k, i, dut_v, exp_v()); end
            checks++;
            if (i == 2 && {vrm_trigger[0], data_release[0]} !== 2'b01) begin
               errors++; $display("FAIL clamp_edge d=%0d got=%b exp=01", k, {vrm_trigger[0], data_release[0]});
            end
            if (i == 2) checks++;
         end
      end
   endtask

   task automatic test_abort();
      delay_ns[0 +: CW] = 10;
      for (int i = 0; i < 22; i++) begin
         step({3'b0, i == 0 || i == 8}, {3'b0, i == 5 || i == 19 || i == 20}, {3'b0, i == 21});
         if (dut_v !== exp_v()) begin errors++; $display("FAIL abort i=%0d got=%h exp=%h", i, dut_v, exp_v()); end
         checks++;
         if (i == 6 && busy[0] !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b exp=0", busy[0]); end
         if (i == 8 && busy[0] !== 1'b1) begin errors++; $display("FAIL abort_reaccept busy=%b exp=1", busy[0]); end
         if (i == 20 && data_release[0] !== 1'b1) begin errors++; $display("FAIL abort_release_held got=%b exp=1", data_release[0]); end
         if (i == 6 || i == 8 || i == 20) checks++;
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d0;
      delay_ns[0 +: CW] = 5;
      d0 = drop_count[DW-1:0];
      for (int i = 0; i < 13; i++) begin
         step({3'b0, i == 0 || i == 6}, '0, {3'b0, i == 6 || i == 12});
         if (dut_v !== exp_v()) begin errors++; $display("FAIL b2b i=%0d got=%h exp=%h", i, dut_v, exp_v()); end
         checks++;
         if (i == 6 && {vrm_trigger[0], data_release[0], drop_count[DW-1:0]} !== {2'b10, d0}) begin
            errors++; $display("FAIL b2b_zero_bubble got=%b exp=%b", {vrm_trigger[0], data_release[0], drop_count[DW-1:0]}, {2'b10, d0});
         end
         if (i == 6) checks++;
      end
   endtask

   task automatic test_drops();
      delay_ns[0 +: CW] = 100;
      for (int i = 0; i < 103; i++) begin
         step({3'b0, i <= 20}, '0, {3'b0, i == 101});
         if (dut_v !== exp_v()) begin errors++; $display("FAIL drops i=%0d got=%h exp=%h", i, dut_v, exp_v()); end
         checks++;
      end
      if (drop_count[DW-1:0] !== 4'hf) begin errors++; $display("FAIL drops_sat got=%h exp=f", drop_count[DW-1:0]); end
      checks++;
   endtask

   task automatic test_concurrency_reset();
      delay_ns = {32'd15, 32'd11, 32'd7, 32'd3};
      for (int i = 0; i < 18; i++) begin
         step(i == 0 ? 4'hf : 4'h0, '0, rel_bits());
         if (dut_v !== exp_v()) begin errors++; $display("FAIL conc i=%0d got=%h exp=%h", i, dut_v, exp_v()); end
         checks++;
      end
      for (int i = 0; i < 5; i++) step(i == 0 ? 4'hf : 4'h0, '0, '0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      if ({vrm_trigger, data_release, busy, drop_count} !== 28'h0) begin
         errors++; $display("FAIL midreset got=%h exp=0", dut_v);
      end
      checks++;
      @(posedge clk); #2 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step('0, '0, '0);
         if (dut_v !== exp_v()) begin errors++; $display("FAIL postreset i=%0d got=%h exp=%h", i, dut_v, exp_v()); end
         checks++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         logic [NC-1:0] pd, ab, ack;
         for (int c = 0; c < NC; c++) begin
            delay_ns[c*CW +: CW] = $urandom_range(0, 12);
            pd[c]  = ($urandom_range(0, 2) == 0);
            ab[c]  = ($urandom_range(0, 7) == 0);
            ack[c] = ($urandom_range(0, 1) == 0);
         end
         step(pd, ab, ack);
         if (dut_v !== exp_v()) begin errors++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_v, exp_v()); end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clamp();
      test_abort();
      test_back_to_back();
      test_drops();
      test_concurrency_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
